// File: rtl/prm_edge_query_seq.sv
// Query sequencer: walks the edge-code RAM, drives the obstacle checker and
// packs the returned mask bits into 32-bit words streamed over valid/ready.
module prm_edge_query_seq #(
  parameter int EDGE_AW = 10,
  parameter int CODE_W  = 15,
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [EDGE_AW:0]   edge_cnt,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [EDGE_AW-1:0] mem_addr,
  input  logic [CODE_W-1:0]  mem_rdata,
  output logic [CODE_W-1:0]  chk_code,
  input  logic               chk_mask,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WORD_W-1:0]  res_data,
  output logic               res_last
);

  localparam int BP_W = $clog2(WORD_W);
  localparam logic [EDGE_AW:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [EDGE_AW:0]    last_idx_q, last_idx_d;
  logic [EDGE_AW:0]    iss_q, iss_d;
  logic                rd_vld_q, rd_vld_d;
  logic [EDGE_AW:0]    rd_idx_q, rd_idx_d;
  logic                chk_vld_q, chk_vld_d;
  logic [EDGE_AW:0]    chk_idx_q, chk_idx_d;
  logic [CODE_W-1:0]   chk_code_q, chk_code_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic                res_last_q, res_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                advance, issue, sample, word_done, hs, accept;
  logic                last_sample;
  logic [BP_W-1:0]     bit_pos;
  logic [WORD_W-1:0]   word_new;

  assign advance     = !(res_valid_q && !res_ready);
  assign hs          = res_valid_q && res_ready;
  assign issue       = (state_q == RUN) && advance;
  assign sample      = chk_vld_q && advance;
  assign bit_pos     = chk_idx_q[BP_W-1:0];
  assign last_sample = sample && (chk_idx_q == last_idx_q);
  assign word_done   = sample && ((&bit_pos) || (chk_idx_q == last_idx_q));
  assign accept      = (state_q == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start && (edge_cnt != '0)) state_d = RUN;
      RUN:   if (issue && (iss_q == last_idx_q)) state_d = DRAIN;
      DRAIN: if (last_sample) state_d = FLUSH;
      FLUSH: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd_en = issue;
    mem_addr  = iss_q[EDGE_AW-1:0];
    chk_code  = chk_code_q;
    res_valid = res_valid_q;
    res_data  = res_data_q;
    res_last  = res_last_q;
    busy      = busy_q;
    done      = done_q;
  end

  // Pipeline, accumulator and output register
  always_comb begin
    last_idx_d  = last_idx_q;
    iss_d       = iss_q;
    rd_vld_d    = rd_vld_q;
    rd_idx_d    = rd_idx_q;
    chk_vld_d   = chk_vld_q;
    chk_idx_d   = chk_idx_q;
    chk_code_d  = chk_code_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    word_new    = acc_q;
    word_new[bit_pos] = chk_mask;

    if (accept && (edge_cnt != '0)) begin
      last_idx_d = edge_cnt - ONE;
      iss_d      = '0;
      acc_d      = '0;
    end
    if (issue) iss_d = iss_q + ONE;
    if (advance) begin
      rd_vld_d  = issue;
      rd_idx_d  = iss_q;
      chk_vld_d = rd_vld_q;
      chk_idx_d = rd_idx_q;
      if (rd_vld_q) chk_code_d = mem_rdata;
    end
    // A word completing during a handshake overwrites the freed register directly.
    if (hs) begin
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
    end
    if (sample) begin
      acc_d = word_new;
      if (word_done) begin
        res_data_d  = word_new;
        res_valid_d = 1'b1;
        res_last_d  = (chk_idx_q == last_idx_q);
        acc_d       = '0;
      end
    end

    done_d = (accept && (edge_cnt == '0)) || ((state_q == FLUSH) && hs);
    busy_d = (state_d != IDLE) || ((state_q == FLUSH) && hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_q  <= '0;
      iss_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      chk_vld_q   <= 1'b0;
      chk_idx_q   <= '0;
      chk_code_q  <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      last_idx_q  <= last_idx_d;
      iss_q       <= iss_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      chk_vld_q   <= chk_vld_d;
      chk_idx_q   <= chk_idx_d;
      chk_code_q  <= chk_code_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Scoreboard bench for prm_edge_query_seq: RAM and checker models, expected
// packed words queued at pass start and compared at each result handshake.
module tb_prm_edge_query_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] edge_cnt = '0;
  logic        busy, done, mem_rd_en, res_valid, res_last, chk_mask;
  logic [9:0]  mem_addr;
  logic [14:0] mem_rdata = '0;
  logic [14:0] chk_code;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;

  prm_edge_query_seq #(.EDGE_AW(10), .CODE_W(15), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .edge_cnt(edge_cnt),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .chk_code(chk_code), .chk_mask(chk_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [14:0] ram [1024];
  int          rd_cnt [1024];
  int          mode = 0;
  int          cyc = 0;
  int          c0 = 0;
  logic [31:0] exp_data_q [$];
  logic        exp_last_q [$];
  int          hs_n = 0;
  int          hs_cyc [64];
  int          valid_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  function automatic logic mask_fn(input logic [14:0] code, input int m);
    case (m)
      0:       return code[0];
      1:       return 1'b1;
      default: return ^code;
    endcase
  endfunction

  assign chk_mask = mask_fn(chk_code, mode);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_rdata <= ram[mem_addr];
      rd_cnt[mem_addr] <= rd_cnt[mem_addr] + 1;
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) valid_seen++;
      if (prev_stall) check("hold_data", res_data, prev_data);
      if (res_valid && !res_ready) check("rd_in_stall", mem_rd_en, 0);
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      if (res_valid && res_ready) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("res_data", res_data, exp_data_q.pop_front());
          check("res_last", res_last, exp_last_q.pop_front());
        end
        if (hs_n < 64) hs_cyc[hs_n] = cyc - c0;
        hs_n++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load_pass(input int n, input int m);
    logic [31:0] w;
    mode = m;
    for (int k = 0; k < 1024; k++) begin
      ram[k] = (m == 0) ? 15'(k) : 15'($urandom);
      rd_cnt[k] = 0;
    end
    exp_data_q.delete();
    exp_last_q.delete();
    for (int wi = 0; wi * 32 < n; wi++) begin
      w = '0;
      for (int i = 0; i < 32; i++)
        if (wi * 32 + i < n) w[i] = mask_fn(ram[wi * 32 + i], m);
      exp_data_q.push_back(w);
      exp_last_q.push_back((wi + 1) * 32 >= n);
    end
    hs_n = 0;
    valid_seen = 0;
  endtask

  task automatic run_pass(input int n, input int m, input int st0, input int stl,
                          input int restart_at);
    int cycle;
    int done_at;
    load_pass(n, m);
    @(posedge clk); #2;
    start = 1'b1;
    edge_cnt = 11'(n);
    c0 = cyc;
    done_at = -1;
    for (int t = 0; t < n + stl + 200; t++) begin
      @(posedge clk); #2;
      cycle = cyc - c0;
      start = (cycle == restart_at);
      edge_cnt = 11'($urandom_range(0, 1024));
      res_ready = !(cycle >= st0 && cycle < st0 + stl);
      if (cycle == 1) check("busy_c1", busy, (n != 0));
      if (done) begin
        done_at = cycle;
        break;
      end
    end
    check("done_cycle", done_at, (n == 0) ? 1 : n + 4 + stl);
    check("word_count", hs_n, (n + 31) / 32);
    check("queue_empty", exp_data_q.size(), 0);
    @(posedge clk); #2;
    start = 1'b0;
    res_ready = 1'b1;
    check("busy_after", busy, 0);
    check("done_pulse", done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", res_valid, 0);
    check("rst_last", res_last, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_code", chk_code, 0);
    check("rst_data", res_data, 0);
    rst_n = 1'b1;
    @(posedge clk);

    run_pass(32, 0, 0, 0, -1);
    check("w0_cycle_32", hs_cyc[0], 35);

    run_pass(40, 1, 0, 0, -1);
    check("w0_cycle_40", hs_cyc[0], 35);
    check("w1_cycle_40", hs_cyc[1], 43);

    run_pass(64, 2, 35, 5, -1);
    check("w0_accept_stall", hs_cyc[0], 40);
    check("w1_cycle_stall", hs_cyc[1], 72);

    run_pass(0, 0, 0, 0, -1);
    check("zero_no_valid", valid_seen, 0);

    run_pass(1024, 2, 0, 0, 500);
    begin
      int nbad = 0;
      for (int k = 0; k < 1024; k++) if (rd_cnt[k] != 1) nbad++;
      check("reads_once", nbad, 0);
    end

    run_pass(5, 2, 0, 0, -1);
    check("w0_cycle_5", hs_cyc[0], 8);

    // Reset in the middle of a 100-edge pass
    load_pass(100, 2);
    @(posedge clk); #2;
    start = 1'b1;
    edge_cnt = 11'd100;
    c0 = cyc;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", mem_rd_en, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_code", chk_code, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_data", res_data, 0);
    exp_data_q.delete();
    exp_last_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    begin
      int dseen = 0;
      for (int t = 0; t < 10; t++) begin
        @(posedge clk); #2;
        if (done || res_valid) dseen++;
      end
      check("no_done_after_rst", dseen, 0);
    end
    run_pass(100, 2, 0, 0, -1);
    check("w3_cycle_100", hs_cyc[3], 103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prm_edge_query_seq.md
# prm_edge_query_seq

Query sequencer that drives one PRM obstacle-logic checker (a combinational 15-bit code → `edge_mask` function) across a whole roadmap edge list. It reads per-edge 15-bit configuration codes from a synchronous code RAM, presents each code to the checker and samples the returned mask bit. It packs the bits 32 per word and streams the packed collision words to the roadmap update logic over a valid/ready interface. It is the initiator side of the checker interface: it sits between the edge-code RAM and the checker bank, and feeds the edge-validity bitmap writer.

## Interface
- `EDGE_AW`, 10, edge index width; max edges = 2^EDGE_AW
- `CODE_W`, 15, checker code width (bit 0 = checker input A … bit 14 = input O)
- `WORD_W`, 32, packed result word width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  begin a pass; sampled only in IDLE
- `edge_cnt`  in  EDGE_AW+1  number of edges, 0..2^EDGE_AW; captured on accepted `start`
- `busy`  out  1  high from cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at pass end
- `mem_rd_en`  out  1  code RAM read strobe
- `mem_addr`  out  EDGE_AW  code RAM address (edge index)
- `mem_rdata`  in  CODE_W  RAM data, valid cycle after `mem_rd_en`, held until next read
- `chk_code`  out  CODE_W  registered code presented to checker
- `chk_mask`  in  1  checker result for current `chk_code` (combinational, same cycle)
- `res_valid`  out  1  packed word available
- `res_ready`  in  1  consumer accepts word when high with `res_valid`
- `res_data`  out  WORD_W  bit i = mask of edge (word_idx·32 + i); unused upper bits 0
- `res_last`  out  1  qualifies final word of the pass

## Operation
- FSM: IDLE → RUN → DRAIN → FLUSH → IDLE.
  - IDLE: `start`=1 captures `edge_cnt`. If 0 → pulse `done` next cycle, stay IDLE. Otherwise → RUN.
  - RUN: issue one read per advancing cycle, addr 0..edge_cnt-1. After last issue → DRAIN.
  - DRAIN: let the in-flight codes be sampled. When last mask bit is captured → FLUSH.
  - FLUSH: hold final word until handshake; then `done` pulse, → IDLE.
- Three-stage pipeline:
  - S0: issue `mem_rd_en`/`mem_addr`.
  - S1: register `mem_rdata` into `chk_code`.
  - S2: sample `chk_mask` into the accumulator at bit position (edge index mod 32).
- Global advance = !(res_valid & !res_ready). When not advancing:
  - `mem_rd_en`=0;
  - `chk_code` and accumulator hold;
  - no sample taken.
- Word complete (bit 31 sampled, or last edge sampled): accumulator → output register, `res_valid`=1. `res_last`=1 if it holds the last edge. Accumulator clears.
- Output register is freed on handshake. A completing word in the same cycle as the handshake loads directly (no bubble).
- `start` while busy: ignored. `edge_cnt` changes after capture: ignored.
- Reset mid-pass: all state to IDLE immediately. Partial words are discarded. No `done`.

## Timing
- Reset values: `busy`, `done`, `mem_rd_en`, `res_valid`, `res_last` = 0. `mem_addr`, `chk_code`, `res_data` = 0.
- Cycle numbering, no stall: `start` sampled cycle 0; read of edge k issued cycle 1+k; `chk_code` = code k in cycle 3+k; mask k sampled at end of cycle 3+k.
- Word whose last edge is index e: `res_valid` in cycle e+4.
- N edges, `res_ready`=1: final word valid cycle N+3; `done` cycle N+4; `busy` low cycle N+5.
- Stall of S cycles (total `res_ready`-low cycles while `res_valid`) delays all later events by exactly S.
- Throughput: one edge per cycle when unstalled.

## Test plan
- `edge_cnt`=32, RAM code k yields mask=k[0], `res_ready`=1 → `res_data`=0xAAAAAAAA valid cycle 35 with `res_last`=1; `done` cycle 36.
- `edge_cnt`=40, all masks 1 → word0 0xFFFFFFFF (cycle 35, last=0); word1 0x000000FF (cycle 43, last=1); `done` cycle 44.
- `edge_cnt`=64, `res_ready` low cycles 35–39 → word0 held stable, accepted cycle 40. No reads issued during stall; word1 = expected value at cycle 72; no bits lost.
- `edge_cnt`=0 → `done` pulse cycle 1; `res_valid` never asserted; `busy` stays 0.
- `edge_cnt`=1024 pass, `start` re-pulsed mid-run → ignored; 32 words; last has `res_last`=1; addresses 0..1023 each read exactly once.
- `rst_n` asserted cycle 20 of a 100-edge pass → all outputs 0 same cycle. New `start` after release completes a normal pass.
